alu_unit: RTL and testbench



---
 rtl/alu_unit_pkg.sv | 44 ++++
 rtl/alu_branch_cmp.sv | 24 ++
 rtl/alu_unit.sv | 145 ++++++++++++++
 tb/tb_alu_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// Shared definitions for the integer execution unit: operation encoding,
// ROB tag width and datapath width.
package alu_unit_pkg;

    localparam int XLEN       = 32;
    localparam int OPENUM_W   = 6;
    localparam int ROB_POS_W  = 5;
    localparam logic [ROB_POS_W-1:0] ROB_NO_DEP = '0;

    // Codes above OP_BGEU are unassigned and execute as a no-op that still completes.
    typedef enum logic [OPENUM_W-1:0] {
        OP_NOP   = 6'd0,
        OP_ADD   = 6'd1,
        OP_SUB   = 6'd2,
        OP_AND   = 6'd3,
        OP_OR    = 6'd4,
        OP_XOR   = 6'd5,
        OP_SLL   = 6'd6,
        OP_SRL   = 6'd7,
        OP_SRA   = 6'd8,
        OP_SLT   = 6'd9,
        OP_SLTU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_ANDI  = 6'd12,
        OP_ORI   = 6'd13,
        OP_XORI  = 6'd14,
        OP_SLLI  = 6'd15,
        OP_SRLI  = 6'd16,
        OP_SRAI  = 6'd17,
        OP_SLTI  = 6'd18,
        OP_SLTIU = 6'd19,
        OP_LUI   = 6'd20,
        OP_AUIPC = 6'd21,
        OP_JAL   = 6'd22,
        OP_JALR  = 6'd23,
        OP_BEQ   = 6'd24,
        OP_BNE   = 6'd25,
        OP_BLT   = 6'd26,
        OP_BGE   = 6'd27,
        OP_BLTU  = 6'd28,
        OP_BGEU  = 6'd29
    } openum_t;

endpackage

// File: rtl/alu_branch_cmp.sv
// Combinational branch condition evaluator; non-branch codes report not taken.
module alu_branch_cmp
    import alu_unit_pkg::*;
(
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [OPENUM_W-1:0] openum,
    output logic                taken
);

    always_comb begin
        taken = 1'b0;
        case (openum)
            OP_BEQ:  taken = (a == b);
            OP_BNE:  taken = (a != b);
            OP_BLT:  taken = ($signed(a) <  $signed(b));
            OP_BGE:  taken = ($signed(a) >= $signed(b));
            OP_BLTU: taken = (a <  b);
            OP_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// Single-cycle integer ALU fed by the reservation station, with registered
// result broadcast. Define ALU_PERF_CNT_EN to add op / taken-jump counters.
module alu_unit
    import alu_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 rs_to_alu_enable,
    input  logic [OPENUM_W-1:0]  rs_to_alu_openum,
    input  logic [ROB_POS_W-1:0] rs_to_alu_rob_pos,
    input  logic [XLEN-1:0]      rs_to_alu_rs1_val,
    input  logic [XLEN-1:0]      rs_to_alu_rs2_val,
    input  logic [XLEN-1:0]      rs_to_alu_imm,
    input  logic [XLEN-1:0]      rs_to_alu_pc,
    output logic                 alu_result_ready,
    output logic [ROB_POS_W-1:0] alu_result_rob_pos,
    output logic [XLEN-1:0]      alu_result_val,
    output logic                 alu_result_jump,
    output logic [XLEN-1:0]      alu_result_target
`ifdef ALU_PERF_CNT_EN
    ,
    output logic [31:0]          alu_perf_ops,
    output logic [31:0]          alu_perf_taken
`endif
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic            br_taken;

    logic [XLEN-1:0] val_next;
    logic            jump_next;
    logic [XLEN-1:0] target_next;

    logic                 ready_reg;
    logic [ROB_POS_W-1:0] rob_pos_reg;
    logic [XLEN-1:0]      val_reg;
    logic                 jump_reg;
    logic [XLEN-1:0]      target_reg;

    assign op_a        = rs_to_alu_rs1_val;
    assign pc_plus4    = rs_to_alu_pc + XLEN'(4);
    assign pc_plus_imm = rs_to_alu_pc + rs_to_alu_imm;

    alu_branch_cmp u_branch_cmp (
        .a      (rs_to_alu_rs1_val),
        .b      (rs_to_alu_rs2_val),
        .openum (rs_to_alu_openum),
        .taken  (br_taken)
    );

    // Immediate forms share the R-type datapath with imm substituted for rs2.
    always_comb begin
        op_b = rs_to_alu_rs2_val;
        case (rs_to_alu_openum)
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI,
            OP_SRLI, OP_SRAI, OP_SLTI, OP_SLTIU: op_b = rs_to_alu_imm;
            default: op_b = rs_to_alu_rs2_val;
        endcase
    end

    always_comb begin
        val_next    = '0;
        jump_next   = 1'b0;
        target_next = pc_plus4;
        case (rs_to_alu_openum)
            OP_ADD,  OP_ADDI:  val_next = op_a + op_b;
            OP_SUB:            val_next = op_a - op_b;
            OP_AND,  OP_ANDI:  val_next = op_a & op_b;
            OP_OR,   OP_ORI:   val_next = op_a | op_b;
            OP_XOR,  OP_XORI:  val_next = op_a ^ op_b;
            OP_SLL,  OP_SLLI:  val_next = op_a << op_b[4:0];
            OP_SRL,  OP_SRLI:  val_next = op_a >> op_b[4:0];
            OP_SRA,  OP_SRAI:  val_next = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_SLT,  OP_SLTI:  val_next = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU, OP_SLTIU: val_next = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_LUI:            val_next = rs_to_alu_imm;
            OP_AUIPC:          val_next = pc_plus_imm;
            OP_JAL: begin
                val_next    = pc_plus4;
                jump_next   = 1'b1;
                target_next = pc_plus_imm;
            end
            OP_JALR: begin
                val_next    = pc_plus4;
                jump_next   = 1'b1;
                target_next = (op_a + rs_to_alu_imm) & ~XLEN'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                jump_next   = br_taken;
                target_next = br_taken ? pc_plus_imm : pc_plus4;
            end
            default: ;
        endcase
    end

    // Idle cycles drop ready but keep the last data so downstream sees stable values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ready_reg   <= 1'b0;
            rob_pos_reg <= ROB_NO_DEP;
            val_reg     <= '0;
            jump_reg    <= 1'b0;
            target_reg  <= '0;
        end else if (rdy) begin
            ready_reg <= rs_to_alu_enable;
            if (rs_to_alu_enable) begin
                rob_pos_reg <= rs_to_alu_rob_pos;
                val_reg     <= val_next;
                jump_reg    <= jump_next;
                target_reg  <= target_next;
            end
        end
    end

    assign alu_result_ready   = ready_reg;
    assign alu_result_rob_pos = rob_pos_reg;
    assign alu_result_val     = val_reg;
    assign alu_result_jump    = jump_reg;
    assign alu_result_target  = target_reg;

`ifdef ALU_PERF_CNT_EN
    logic [31:0] perf_ops_reg;
    logic [31:0] perf_taken_reg;

    // Counters survive a flush; only a full reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_reg   <= '0;
            perf_taken_reg <= '0;
        end else if (rdy && !clr && rs_to_alu_enable) begin
            perf_ops_reg   <= perf_ops_reg + 32'd1;
            perf_taken_reg <= perf_taken_reg + {31'd0, jump_next};
        end
    end

    assign alu_perf_ops   = perf_ops_reg;
    assign alu_perf_taken = perf_taken_reg;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the result broadcast.
module tb_alu_unit;
    import alu_unit_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst, rdy, clr, en;
    logic [OPENUM_W-1:0]  op;
    logic [ROB_POS_W-1:0] tag;
    logic [XLEN-1:0]      rs1, rs2, imm, pc;
    logic                 res_ready, res_jump;
    logic [ROB_POS_W-1:0] res_tag;
    logic [XLEN-1:0]      res_val, res_target;
`ifdef ALU_PERF_CNT_EN
    logic [31:0]          perf_ops, perf_taken;
`endif

    int errors = 0;
    int checks = 0;

    logic                 exp_ready, exp_jump;
    logic [ROB_POS_W-1:0] exp_tag;
    logic [XLEN-1:0]      exp_val, exp_target;
    logic [31:0]          exp_ops, exp_taken;

    always #5 clk = ~clk;

    alu_unit dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .clr                (clr),
        .rs_to_alu_enable   (en),
        .rs_to_alu_openum   (op),
        .rs_to_alu_rob_pos  (tag),
        .rs_to_alu_rs1_val  (rs1),
        .rs_to_alu_rs2_val  (rs2),
        .rs_to_alu_imm      (imm),
        .rs_to_alu_pc       (pc),
        .alu_result_ready   (res_ready),
        .alu_result_rob_pos (res_tag),
        .alu_result_val     (res_val),
        .alu_result_jump    (res_jump),
        .alu_result_target  (res_target)
`ifdef ALU_PERF_CNT_EN
        ,
        .alu_perf_ops       (perf_ops),
        .alu_perf_taken     (perf_taken)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, want);
        end
    endtask

    // Architectural meaning of each operation, straight from the ISA rules.
    function automatic void ref_exec(input logic [OPENUM_W-1:0] o,
                                     input logic [31:0] a, input logic [31:0] r2,
                                     input logic [31:0] im, input logic [31:0] p,
                                     output logic [31:0] v, output logic j,
                                     output logic [31:0] t);
        logic signed [31:0] sa, sr2, sim;
        sa = a; sr2 = r2; sim = im;
        v = 0; j = 0; t = p + 4;
        case (o)
            OP_ADD:   v = a + r2;
            OP_ADDI:  v = a + im;
            OP_SUB:   v = a - r2;
            OP_AND:   v = a & r2;
            OP_ANDI:  v = a & im;
            OP_OR:    v = a | r2;
            OP_ORI:   v = a | im;
            OP_XOR:   v = a ^ r2;
            OP_XORI:  v = a ^ im;
            OP_SLL:   v = a << r2[4:0];
            OP_SLLI:  v = a << im[4:0];
            OP_SRL:   v = a >> r2[4:0];
            OP_SRLI:  v = a >> im[4:0];
            OP_SRA:   v = sa >>> r2[4:0];
            OP_SRAI:  v = sa >>> im[4:0];
            OP_SLT:   v = (sa < sr2) ? 1 : 0;
            OP_SLTI:  v = (sa < sim) ? 1 : 0;
            OP_SLTU:  v = (a < r2) ? 1 : 0;
            OP_SLTIU: v = (a < im) ? 1 : 0;
            OP_LUI:   v = im;
            OP_AUIPC: v = p + im;
            OP_JAL:  begin v = p + 4; j = 1; t = p + im; end
            OP_JALR: begin v = p + 4; j = 1; t = (a + im) & 32'hFFFF_FFFE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (o)
                    OP_BEQ:  j = (a == r2);
                    OP_BNE:  j = (a != r2);
                    OP_BLT:  j = (sa < sr2);
                    OP_BGE:  j = (sa >= sr2);
                    OP_BLTU: j = (a < r2);
                    default: j = (a >= r2);
                endcase
                t = j ? p + im : p + 4;
            end
            default: ;
        endcase
    endfunction

    // Advance one clock: predict the registered outputs, step, compare all of them.
    task automatic tick(input string name);
        logic [31:0] v, t;
        logic        j;
        ref_exec(op, rs1, rs2, imm, pc, v, j, t);
        if (rst) begin
            exp_ready = 0; exp_tag = 0; exp_val = 0; exp_jump = 0; exp_target = 0;
            exp_ops = 0; exp_taken = 0;
        end else if (clr) begin
            exp_ready = 0; exp_tag = 0; exp_val = 0; exp_jump = 0; exp_target = 0;
        end else if (rdy) begin
            exp_ready = en;
            if (en) begin
                exp_tag = tag; exp_val = v; exp_jump = j; exp_target = t;
                exp_ops++;
                if (j) exp_taken++;
            end
        end
        @(posedge clk);
        #1;
        check({name, ".ready"},  res_ready,  exp_ready);
        check({name, ".tag"},    res_tag,    exp_tag);
        check({name, ".val"},    res_val,    exp_val);
        check({name, ".jump"},   res_jump,   exp_jump);
        check({name, ".target"}, res_target, exp_target);
`ifdef ALU_PERF_CNT_EN
        check({name, ".ops"},    perf_ops,   exp_ops);
        check({name, ".taken"},  perf_taken, exp_taken);
`endif
    endtask

    task automatic issue(input logic [OPENUM_W-1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] p, input logic [ROB_POS_W-1:0] tg);
        en = 1; op = o; rs1 = a; rs2 = b; imm = im; pc = p; tag = tg;
    endtask

    logic [31:0] held_val;

    initial begin
        rst = 1; rdy = 1; clr = 0; en = 0; op = 0; tag = 0;
        rs1 = 0; rs2 = 0; imm = 0; pc = 0;
        exp_ops = 0; exp_taken = 0;
        #1;

        // Reset then idle
        tick("reset0");
        tick("reset1");
        check("reset_val", res_val, 32'd0);
        rst = 0;
        for (int i = 0; i < 3; i++) tick("idle");
        check("idle_ready", res_ready, 1'b0);

        // ADD then SUB back-to-back
        issue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h40, 5'd3);
        tick("add");
        check("add_val", res_val, 32'd12);
        check("add_tag", res_tag, 32'd3);
        issue(OP_SUB, 32'd5, 32'd7, 32'd0, 32'h44, 5'd4);
        tick("sub");
        check("sub_val", res_val, 32'hFFFF_FFFE);
        check("sub_ready", res_ready, 1'b1);
        en = 0;
        tick("after_sub");
        check("after_sub_val_hold", res_val, 32'hFFFF_FFFE);

        // Signed vs unsigned branch resolution
        issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd5);
        tick("blt");
        check("blt_jump", res_jump, 1'b1);
        check("blt_target", res_target, 32'h120);
        issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd6);
        tick("bltu");
        check("bltu_jump", res_jump, 1'b0);
        check("bltu_target", res_target, 32'h104);

        // JALR clears bit 0 of the target
        issue(OP_JALR, 32'h1001, 32'd0, 32'd4, 32'h200, 5'd7);
        tick("jalr");
        check("jalr_val", res_val, 32'h204);
        check("jalr_target", res_target, 32'h1004);

        // PC wrap and unknown opcode
        issue(OP_JAL, 32'd0, 32'd0, 32'd8, 32'hFFFF_FFFC, 5'd8);
        tick("jal_wrap");
        check("jal_wrap_val", res_val, 32'd0);
        issue(6'd63, 32'd9, 32'd9, 32'd9, 32'h300, 5'd9);
        tick("unknown");
        check("unknown_target", res_target, 32'h304);

        // Dispatch alongside clr is dropped
        issue(OP_ADDI, 32'd1, 32'd0, 32'd1, 32'h400, 5'd10);
        clr = 1;
        tick("clr_drop");
        check("clr_ready", res_ready, 1'b0);
        clr = 0;

        // rdy=0 holds everything, including ready=1, and ignores dispatch
        issue(OP_XORI, 32'hF0F0_F0F0, 32'd0, 32'h0FF0_0FF0, 32'h500, 5'd11);
        tick("pre_stall");
        held_val = res_val;
        rdy = 0;
        issue(OP_SUB, 32'd100, 32'd1, 32'd0, 32'h504, 5'd12);
        tick("stall0");
        tick("stall1");
        check("stall_ready", res_ready, 1'b1);
        check("stall_val", res_val, held_val);
        rdy = 1; en = 0;
        tick("resume");

`ifdef ALU_PERF_CNT_EN
        rst = 1; tick("perf_rst"); rst = 0;
        issue(OP_ADD,  32'd1, 32'd2, 32'd0, 32'h0, 5'd1); tick("perf1");
        issue(OP_BEQ,  32'd3, 32'd3, 32'h8, 32'h4, 5'd2); tick("perf2");
        issue(OP_OR,   32'd1, 32'd2, 32'd0, 32'h8, 5'd3); tick("perf3");
        issue(OP_BNE,  32'd3, 32'd4, 32'h8, 32'hC, 5'd4); tick("perf4");
        issue(OP_BEQ,  32'd3, 32'd4, 32'h8, 32'h10, 5'd5); tick("perf5");
        en = 0; clr = 1; tick("perf_clr"); clr = 0;
        check("perf_ops_final", perf_ops, 32'd5);
        check("perf_taken_final", perf_taken, 32'd2);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            clr = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            en  = ($urandom_range(0, 3) != 0);
            op  = 6'($urandom_range(0, 33));
            tag = 5'($urandom_range(1, 31));
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            pc  = {$urandom, 2'b00} >> 0;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
